// File: rtl/fp_pkg.sv
// Shared single-precision float definitions for the Maxnet datapath (multiplier and divider).
package fp_pkg;

  localparam int unsigned EXP_WIDTH  = 8;
  localparam int unsigned FRAC_WIDTH = 23;
  localparam int unsigned BIAS       = 127;
  localparam int unsigned WORD_W     = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int unsigned MANT_W     = FRAC_WIDTH + 1;
  localparam int unsigned ITER       = FRAC_WIDTH + 2;
  localparam int unsigned EXT_EXP_W  = EXP_WIDTH + 2;

  localparam logic [WORD_W-2:0] FP_INF_MAG = 31'h7F800000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIVIDE    = 2'd1,
    NORMALIZE = 2'd2,
    DONE      = 2'd3
  } div_state_t;

  // No denormals: a zero exponent field means the operand is zero.
  function automatic logic fp_is_zero(input logic [EXP_WIDTH-1:0] exp_field);
    return exp_field == '0;
  endfunction

endpackage

// File: rtl/mantissa_divider.sv
// Restoring mantissa divider: one quotient bit per step, Q = floor(ma * 2^(ITER-1) / mb).
module mantissa_divider
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_init,
  input  logic              i_step,
  input  logic [MANT_W-1:0] i_ma,
  input  logic [MANT_W-1:0] i_mb,
  output logic [ITER-1:0]   o_quot,
  output logic              o_last_c
);

  localparam int unsigned CNT_W = $clog2(ITER + 1);

  logic [ITER-1:0]   r_rem;
  logic [MANT_W-1:0] r_mb;
  logic [ITER-1:0]   r_quot;
  logic [CNT_W-1:0]  r_count;

  logic              w_ge;
  logic [ITER-1:0]   w_diff;

  // Partial remainder stays below 2*mb, so ITER bits never overflow.
  assign w_ge   = r_rem >= {1'b0, r_mb};
  assign w_diff = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem   <= '0;
      r_mb    <= '0;
      r_quot  <= '0;
      r_count <= '0;
    end else if (i_init) begin
      r_rem   <= {1'b0, i_ma};
      r_mb    <= i_mb;
      r_quot  <= '0;
      r_count <= '0;
    end else if (i_step) begin
      r_rem   <= {w_diff[ITER-2:0], 1'b0};
      r_quot  <= {r_quot[ITER-2:0], w_ge};
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_quot   = r_quot;
  assign o_last_c = r_count == CNT_W'(ITER - 1);

endmodule

// File: rtl/ieee754_divider.sv
// Multi-cycle single-precision divider with start/done handshake and fixed latency.
module ieee754_divider
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result,
  output logic              div_by_zero
);

  div_state_t          r_state;
  logic [WORD_W-1:0]   r_a;
  logic [WORD_W-1:0]   r_b;

  logic                w_init;
  logic                w_step;
  logic                w_last_c;
  logic [ITER-1:0]     w_quot;
  logic                w_sign;
  logic                w_a_zero;
  logic                w_b_zero;
  logic [EXT_EXP_W-1:0] w_ediff;
  logic [EXT_EXP_W-1:0] w_exp;
  logic [FRAC_WIDTH-1:0] w_frac;
  logic                w_ovf;
  logic                w_unf;
  logic [WORD_W-1:0]   w_res;

  assign w_init = (r_state == IDLE) && start;
  assign w_step = r_state == DIVIDE;

  mantissa_divider u_mant (
    .clk      (clk),
    .rst      (rst),
    .i_init   (w_init),
    .i_step   (w_step),
    .i_ma     ({1'b1, a[FRAC_WIDTH-1:0]}),
    .i_mb     ({1'b1, b[FRAC_WIDTH-1:0]}),
    .o_quot   (w_quot),
    .o_last_c (w_last_c)
  );

  assign w_sign   = r_a[WORD_W-1] ^ r_b[WORD_W-1];
  assign w_a_zero = fp_is_zero(r_a[WORD_W-2 -: EXP_WIDTH]);
  assign w_b_zero = fp_is_zero(r_b[WORD_W-2 -: EXP_WIDTH]);

  // Two's-complement exponent in EXT_EXP_W bits; bit 9 set means negative.
  assign w_ediff = EXT_EXP_W'(r_a[WORD_W-2 -: EXP_WIDTH])
                 - EXT_EXP_W'(r_b[WORD_W-2 -: EXP_WIDTH])
                 + EXT_EXP_W'(BIAS);
  assign w_exp   = w_quot[ITER-1] ? w_ediff : (w_ediff - EXT_EXP_W'(1));
  assign w_frac  = w_quot[ITER-1] ? w_quot[ITER-2:1] : w_quot[FRAC_WIDTH-1:0];
  assign w_ovf   = !w_exp[EXT_EXP_W-1] && (w_exp >= EXT_EXP_W'(255));
  assign w_unf   = w_exp[EXT_EXP_W-1] || (w_exp == '0);

  // Special-case priority: divide by zero, zero dividend, overflow, underflow.
  always_comb begin
    w_res = {w_sign, w_exp[EXP_WIDTH-1:0], w_frac};
    if (w_b_zero) begin
      w_res = {w_sign, FP_INF_MAG};
    end else if (w_a_zero) begin
      w_res = '0;
    end else if (w_ovf) begin
      w_res = {w_sign, FP_INF_MAG};
    end else if (w_unf) begin
      w_res = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a         <= a;
            r_b         <= b;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            r_state     <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (w_last_c) begin
            r_state <= NORMALIZE;
          end
        end
        NORMALIZE: begin
          result      <= w_res;
          div_by_zero <= w_b_zero;
          done        <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ieee754_divider.sv
// Directed and randomized checks of ieee754_divider against an integer-arithmetic reference.
module tb_ieee754_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  int vectors    = 0;
  int miscompares = 0;

  ieee754_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference quotient from the arithmetic rules: integer division, truncation, range clamps.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic            s;
    longint unsigned ma;
    longint unsigned mb;
    longint unsigned q;
    int              e;
    logic [22:0]     f;
    s = x[31] ^ y[31];
    if (y[30:23] == 8'd0) return {s, 8'hFF, 23'h0};
    if (x[30:23] == 8'd0) return 32'h0;
    ma = 64'h800000 | 64'(x[22:0]);
    mb = 64'h800000 | 64'(y[22:0]);
    q  = (ma << 24) / mb;
    e  = int'(x[30:23]) - int'(y[30:23]) + 127;
    if (q >= 64'h1000000) begin
      f = 23'(q >> 1);
    end else begin
      f = 23'(q);
      e = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return 32'h0;
    return {s, 8'(e), f};
  endfunction

  task automatic do_div(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                        input bit repulse);
    int          first_done;
    int          n_done;
    logic [31:0] exp_res;
    logic        exp_dz;
    logic [31:0] res_at_done;
    logic        dz_at_done;
    exp_res     = ref_div(ta, tbv);
    exp_dz      = (tbv[30:23] == 8'd0);
    first_done  = -1;
    n_done      = 0;
    res_at_done = 32'hDEADBEEF;
    dz_at_done  = 1'bx;
    @(negedge clk);
    a = ta; b = tbv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    check({tag, " busy"}, 32'(busy), 32'd1);
    for (int c = 1; c <= 32; c++) begin
      start = (repulse && (c == 3 || c == 26 || c == 27)) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        n_done++;
        if (first_done < 0) begin
          first_done  = c;
          res_at_done = result;
          dz_at_done  = div_by_zero;
        end
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(first_done), 32'd26);
    check({tag, " done_count"}, 32'(n_done), 32'd1);
    check({tag, " result"}, res_at_done, exp_res);
    check({tag, " div_by_zero"}, 32'(dz_at_done), 32'(exp_dz));
    check({tag, " held"}, result, exp_res);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          n_done_after_rst;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    check("reset dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div("6/2", 32'h40C00000, 32'h40000000, 1'b0);
    check("6/2 const", result, 32'h40400000);
    do_div("1/3", 32'h3F800000, 32'h40400000, 1'b0);
    check("1/3 const", result, 32'h3EAAAAAA);
    do_div("-1/0.5", 32'hBF800000, 32'h3F000000, 1'b0);
    check("-1/0.5 const", result, 32'hC0000000);
    do_div("1/0", 32'h3F800000, 32'h00000000, 1'b0);
    check("1/0 const", result, 32'h7F800000);
    check("1/0 flag", 32'(div_by_zero), 32'd1);
    do_div("0/5", 32'h00000000, 32'h40A00000, 1'b0);
    check("0/5 flag cleared", 32'(div_by_zero), 32'd0);
    do_div("0/0", 32'h00000000, 32'h00000000, 1'b0);
    do_div("overflow", 32'h7F000000, 32'h00800000, 1'b0);
    check("overflow const", result, 32'h7F800000);
    do_div("underflow", 32'h00800000, 32'h7F000000, 1'b0);
    check("underflow const", result, 32'h00000000);
    do_div("repulse", 32'h40C00000, 32'h40000000, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        ra[30:23] = 8'($urandom_range(90, 165));
        rb[30:23] = 8'($urandom_range(90, 165));
      end
      if ($urandom_range(0, 12) == 0) ra[30:23] = 8'd0;
      if ($urandom_range(0, 12) == 0) rb[30:23] = 8'd0;
      do_div("random", ra, rb, 1'b0);
    end

    // Reset ten cycles into an operation must abort it without a done pulse.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done_after_rst = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done_after_rst++;
    end
    check("midrst no_done", 32'(n_done_after_rst), 32'd0);
    do_div("after_rst", 32'h40C00000, 32'h40000000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
